dcache_dm: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate data cache between the store/load buffer (SLB) and the memory controller (MC). Loads that hit return in one cycle without touching the MC. Misses, stores and IO-region accesses go to the MC as single transactions. An in-flight load's result can be squashed by a pipeline flush.

---
 rtl/dcache_dm.sv | 192 +++++++++++++++++++
 tb/tb_dcache_dm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache between the SLB and the memory controller.
// Single-word lines; load hits answer in one cycle, everything else is one MC transaction.
module dcache_dm #(
    parameter int LINES = 64,
    parameter int ADDR_W = 32,
    parameter int NICK_W = 4,
    parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iFlush,
    input  logic              iSLB_en,
    input  logic              iSLB_ls,
    input  logic [ADDR_W-1:0] iSLB_pc,
    input  logic [31:0]       iSLB_dt,
    input  logic [2:0]        iSLB_len,
    input  logic [NICK_W-1:0] iSLB_nick,
    output logic              oSLB_en,
    output logic              oSLB_done,
    output logic [31:0]       oSLB_dt,
    output logic [NICK_W-1:0] oSLB_nick,
    output logic              oMC_en,
    output logic              oMC_ls,
    output logic [ADDR_W-1:0] oMC_pc,
    output logic [31:0]       oMC_dt,
    output logic [2:0]        oMC_len,
    input  logic              iMC_done,
    input  logic [31:0]       iMC_dt
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    function automatic logic [31:0] f_mask(input logic [2:0] len);
        case (len)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            3'd3:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] len);
        return (word >> {off, 3'b000}) & f_mask(len);
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] dt,
                                            input logic [1:0] off, input logic [2:0] len);
        logic [31:0] m;
        m = f_mask(len) << {off, 3'b000};
        return (old & ~m) | ((dt << {off, 3'b000}) & m);
    endfunction

    state_t            r_state;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tags [LINES];
    logic [31:0]       r_data [LINES];

    logic              r_ls;
    logic              r_fill;
    logic [1:0]        r_off;
    logic [2:0]        r_len;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic [NICK_W-1:0] r_nick;

    logic              r_done;
    logic [31:0]       r_slb_dt;
    logic [NICK_W-1:0] r_slb_nick;
    logic              r_mc_en;
    logic              r_mc_ls;
    logic [ADDR_W-1:0] r_mc_pc;
    logic [31:0]       r_mc_dt;
    logic [2:0]        r_mc_len;

    logic [1:0]        w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [3:0]        w_span;
    logic              w_cacheable;
    logic              w_hit;
    logic              w_slb_en;
    logic              w_acc;
    logic              w_fill;
    logic              w_merge;

    assign w_off       = iSLB_pc[1:0];
    assign w_idx       = iSLB_pc[IDX_W+1:2];
    assign w_tag       = iSLB_pc[ADDR_W-1:IDX_W+2];
    assign w_span      = {2'b00, w_off} + {1'b0, iSLB_len};
    assign w_cacheable = (iSLB_pc < IO_BASE) && (w_span <= 4'd4);
    assign w_hit       = w_cacheable && r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_slb_en    = rst && rdy && !iFlush && (r_state == S_IDLE);
    assign w_acc       = w_slb_en && iSLB_en;
    // A fill happens even when the load was squashed, so the line is still usable afterwards.
    assign w_fill      = rdy && iMC_done && r_fill && (r_state == S_WAIT || r_state == S_DRAIN);
    assign w_merge     = w_acc && iSLB_ls && w_hit;

    assign oSLB_en   = w_slb_en;
    assign oSLB_done = r_done && rdy;
    assign oSLB_dt   = r_slb_dt;
    assign oSLB_nick = r_slb_nick;
    assign oMC_en    = r_mc_en && rdy;
    assign oMC_ls    = r_mc_ls;
    assign oMC_pc    = r_mc_pc;
    assign oMC_dt    = r_mc_dt;
    assign oMC_len   = r_mc_len;

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tags[r_idx] <= r_tag;
            r_data[r_idx] <= iMC_dt;
        end else if (w_merge) begin
            r_data[w_idx] <= f_merge(r_data[w_idx], iSLB_dt, w_off, iSLB_len);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_ls       <= 1'b0;
            r_fill     <= 1'b0;
            r_off      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_nick     <= '0;
            r_done     <= 1'b0;
            r_slb_dt   <= '0;
            r_slb_nick <= '0;
            r_mc_en    <= 1'b0;
            r_mc_ls    <= 1'b0;
            r_mc_pc    <= '0;
            r_mc_dt    <= '0;
            r_mc_len   <= '0;
        end else if (rdy) begin
            r_done  <= 1'b0;
            r_mc_en <= 1'b0;
            if (w_fill)
                r_valid[r_idx] <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_ls   <= iSLB_ls;
                        r_off  <= w_off;
                        r_len  <= iSLB_len;
                        r_idx  <= w_idx;
                        r_tag  <= w_tag;
                        r_nick <= iSLB_nick;
                        if (!iSLB_ls && w_hit) begin
                            r_done     <= 1'b1;
                            r_slb_dt   <= f_extract(r_data[w_idx], w_off, iSLB_len);
                            r_slb_nick <= iSLB_nick;
                        end else begin
                            // Cacheable misses fetch the whole aligned word so it can be filled.
                            r_fill   <= !iSLB_ls && w_cacheable;
                            r_mc_en  <= 1'b1;
                            r_mc_ls  <= iSLB_ls;
                            r_mc_pc  <= (!iSLB_ls && w_cacheable) ? {iSLB_pc[ADDR_W-1:2], 2'b00} : iSLB_pc;
                            r_mc_len <= (!iSLB_ls && w_cacheable) ? 3'd4 : iSLB_len;
                            r_mc_dt  <= iSLB_dt;
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_REQ: r_state <= (iFlush && !r_ls) ? S_DRAIN : S_WAIT;
                S_WAIT: begin
                    if (iMC_done) begin
                        r_state <= S_IDLE;
                        if (r_ls) begin
                            r_done     <= 1'b1;
                            r_slb_dt   <= 32'h0;
                            r_slb_nick <= r_nick;
                        end else if (!iFlush) begin
                            r_done     <= 1'b1;
                            r_slb_dt   <= r_fill ? f_extract(iMC_dt, r_off, r_len) : iMC_dt;
                            r_slb_nick <= r_nick;
                        end
                    end else if (iFlush && !r_ls) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: if (iMC_done) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: a byte-memory reference model plus a line-presence table predicts
// every MC request and every SLB response; a monitor checks them as the DUT presents them.
module tb_dcache_dm;
    localparam int LINES = 64;
    localparam int unsigned IO = 32'h30000;

    typedef struct { logic [31:0] dt; logic [3:0] nick; } rsp_t;
    typedef struct { logic ls; logic [31:0] pc; logic [2:0] len; logic [31:0] dt; } mc_t;

    logic clk, rst, rdy, iFlush, iSLB_en, iSLB_ls, iMC_done;
    logic [31:0] iSLB_pc, iSLB_dt, iMC_dt;
    logic [2:0] iSLB_len;
    logic [3:0] iSLB_nick;
    logic oSLB_en, oSLB_done, oMC_en, oMC_ls;
    logic [31:0] oSLB_dt, oMC_pc, oMC_dt;
    logic [3:0] oSLB_nick;
    logic [2:0] oMC_len;

    int total = 0;
    int bad = 0;
    rsp_t exp_rsp[$];
    mc_t exp_mc[$];
    logic [7:0] mem [int unsigned];
    int unsigned ref_line [LINES];
    logic [3:0] nick_ctr = 0;
    bit mc_busy = 0;

    dcache_dm dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iFlush(iFlush),
        .iSLB_en(iSLB_en), .iSLB_ls(iSLB_ls), .iSLB_pc(iSLB_pc), .iSLB_dt(iSLB_dt),
        .iSLB_len(iSLB_len), .iSLB_nick(iSLB_nick),
        .oSLB_en(oSLB_en), .oSLB_done(oSLB_done), .oSLB_dt(oSLB_dt), .oSLB_nick(oSLB_nick),
        .oMC_en(oMC_en), .oMC_ls(oMC_ls), .oMC_pc(oMC_pc), .oMC_dt(oMC_dt), .oMC_len(oMC_len),
        .iMC_done(iMC_done), .iMC_dt(iMC_dt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rdb(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return 8'(a * 13 + 7);
    endfunction

    // Little-endian read of len bytes, zero-extended.
    function automatic logic [31:0] rd(input int unsigned a, input int len);
        logic [31:0] r = 0;
        for (int i = 0; i < len; i++) r = r | (32'(rdb(a + i)) << (8 * i));
        return r;
    endfunction

    // Memory controller: answers after a random latency; holds iMC_done while rdy is low.
    initial begin
        logic [31:0] a;
        logic [2:0] l;
        logic ls_q;
        int lat;
        bit ab;
        iMC_done = 0;
        iMC_dt = 0;
        forever begin
            @(negedge clk);
            if (rst && oMC_en) begin
                mc_busy = 1;
                a = oMC_pc; l = oMC_len; ls_q = oMC_ls;
                lat = $urandom_range(1, 4);
                ab = 0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk);
                    if (!rst) ab = 1;
                end
                if (!ab) begin
                    #1 iMC_done = 1;
                    iMC_dt = ls_q ? 32'h0 : rd(a, int'(l));
                    do @(posedge clk); while (!rdy && rst);
                    #1 iMC_done = 0;
                    iMC_dt = 0;
                end
                mc_busy = 0;
            end
        end
    end

    // Monitor
    initial begin
        rsp_t r;
        mc_t m;
        forever begin
            @(negedge clk);
            if (rst && !rdy) begin
                chk("frozen_slb_en", 32'(oSLB_en), 0);
                chk("frozen_done", 32'(oSLB_done), 0);
                chk("frozen_mc_en", 32'(oMC_en), 0);
            end
            if (oSLB_done) begin
                chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) begin
                    r = exp_rsp.pop_front();
                    chk("rsp_dt", oSLB_dt, r.dt);
                    chk("rsp_nick", 32'(oSLB_nick), 32'(r.nick));
                end
            end
            if (oMC_en) begin
                chk("mc_expected", 32'(exp_mc.size() != 0), 1);
                if (exp_mc.size() != 0) begin
                    m = exp_mc.pop_front();
                    chk("mc_ls", 32'(oMC_ls), 32'(m.ls));
                    chk("mc_pc", oMC_pc, m.pc);
                    chk("mc_len", 32'(oMC_len), 32'(m.len));
                    if (m.ls) chk("mc_dt", oMC_dt, m.dt);
                end
            end
        end
    end

    task automatic wait_accept_ready();
        int n = 0;
        while (!oSLB_en && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_ready", 32'(oSLB_en), 1);
    endtask

    task automatic do_req(input bit ls, input logic [31:0] pc, input logic [2:0] len,
                          input logic [31:0] dt, input int flush_req, input int stall);
        bit cach, hit;
        int unsigned w, idx;
        int n, flush_at;
        wait_accept_ready();
        if (!oSLB_en) return;
        cach = (pc < IO) && ((pc % 4) + len <= 4);
        w = pc >> 2;
        idx = w % LINES;
        hit = !ls && cach && (ref_line[idx] == w + 1);
        flush_at = hit ? 0 : flush_req;
        if (ls) begin
            exp_mc.push_back('{1'b1, pc, len, dt});
            exp_rsp.push_back('{32'h0, nick_ctr});
            for (int i = 0; i < int'(len); i++) mem[pc + 32'(i)] = dt[8*i +: 8];
        end else if (hit) begin
            exp_rsp.push_back('{rd(pc, int'(len)), nick_ctr});
        end else begin
            exp_mc.push_back('{1'b0, cach ? (pc & 32'hFFFF_FFFC) : pc, cach ? 3'd4 : len, 32'h0});
            if (cach) ref_line[idx] = w + 1;
            if (flush_at == 0) exp_rsp.push_back('{rd(pc, int'(len)), nick_ctr});
        end
        iSLB_en = 1; iSLB_ls = ls; iSLB_pc = pc; iSLB_len = len; iSLB_dt = dt; iSLB_nick = nick_ctr;
        @(posedge clk);
        #1 iSLB_en = 0;
        #1;
        chk("first_cycle_done", 32'(oSLB_done), 32'(hit));
        chk("first_cycle_mc_en", 32'(oMC_en), 32'(!hit));
        nick_ctr++;
        if (flush_at > 0) begin
            if (flush_at == 2) begin @(posedge clk); #2; end
            iFlush = 1;
            @(posedge clk); #2 iFlush = 0;
        end else if (stall > 0) begin
            @(posedge clk); #2 rdy = 0;
            repeat (stall) @(posedge clk);
            #2 rdy = 1;
        end
        n = 0;
        while (!(exp_rsp.size() == 0 && exp_mc.size() == 0 && !mc_busy && oSLB_en) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("completion_in_time", 32'(n < 200), 1);
    endtask

    task automatic reset_mid_transaction();
        int n = 0;
        wait_accept_ready();
        exp_mc.push_back('{1'b0, 32'h2F000, 3'd4, 32'h0});
        iSLB_en = 1; iSLB_ls = 0; iSLB_pc = 32'h2F000; iSLB_len = 4; iSLB_nick = nick_ctr;
        @(posedge clk);
        #1 iSLB_en = 0;
        @(posedge clk); #2 rst = 0;
        #1;
        chk("rst_slb_en", 32'(oSLB_en), 0);
        chk("rst_done", 32'(oSLB_done), 0);
        chk("rst_mc_en", 32'(oMC_en), 0);
        chk("rst_mc_pc", oMC_pc, 0);
        chk("rst_slb_dt", oSLB_dt, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1;
        for (int i = 0; i < LINES; i++) ref_line[i] = 0;
        while (mc_busy && n < 50) begin @(posedge clk); #2; n++; end
        repeat (3) @(posedge clk);
        #2;
        chk("no_rsp_after_reset", 32'(exp_rsp.size()), 0);
    endtask

    initial begin
        logic [31:0] bases [9];
        logic [31:0] pc, dt;
        logic [2:0] len;
        bit ls;
        int fl, st;
        bases = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h300, 32'h2FFFC, 32'h30000, 32'h30004};
        rst = 0; rdy = 1; iFlush = 0; iSLB_en = 0; iSLB_ls = 0;
        iSLB_pc = 0; iSLB_dt = 0; iSLB_len = 0; iSLB_nick = 0;
        for (int i = 0; i < LINES; i++) ref_line[i] = 0;
        mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_slb_en", 32'(oSLB_en), 0);
        chk("reset_done", 32'(oSLB_done), 0);
        chk("reset_mc_en", 32'(oMC_en), 0);
        chk("reset_mc_pc", oMC_pc, 0);
        chk("reset_mc_len", 32'(oMC_len), 0);
        chk("reset_slb_dt", oSLB_dt, 0);
        chk("reset_slb_nick", 32'(oSLB_nick), 0);
        rst = 1;
        @(posedge clk); #2;

        do_req(0, 32'h100, 4, 0, 0, 0);
        do_req(0, 32'h100, 4, 0, 0, 0);
        do_req(0, 32'h102, 2, 0, 0, 0);
        do_req(0, 32'h103, 2, 0, 0, 0);
        do_req(1, 32'h101, 1, 32'h55, 0, 0);
        do_req(0, 32'h100, 4, 0, 0, 0);
        do_req(1, 32'h200, 4, 32'h1234_5678, 0, 0);
        do_req(0, 32'h200, 4, 0, 0, 0);
        do_req(0, 32'h100, 4, 0, 0, 3);
        do_req(0, 32'h30000, 4, 0, 0, 0);
        do_req(0, 32'h30000, 2, 0, 0, 0);
        do_req(0, 32'h140, 4, 0, 2, 0);
        do_req(0, 32'h140, 4, 0, 0, 0);
        do_req(0, 32'h144, 2, 0, 1, 0);
        do_req(0, 32'h146, 2, 0, 0, 0);
        do_req(1, 32'h148, 4, 32'hCAFE_F00D, 2, 0);
        do_req(0, 32'h148, 4, 0, 0, 4);
        reset_mid_transaction();
        do_req(0, 32'h100, 4, 0, 0, 0);
        do_req(0, 32'h100, 1, 0, 0, 0);

        for (int k = 0; k < 250; k++) begin
            ls = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0: len = 1;
                1: len = 2;
                default: len = 4;
            endcase
            pc = bases[$urandom_range(0, 8)];
            if (!ls && $urandom_range(0, 3) == 0) pc = pc + 32'($urandom_range(0, 3));
            else if (len == 2) pc = pc + 32'(2 * $urandom_range(0, 1));
            else if (len == 1) pc = pc + 32'($urandom_range(0, 3));
            dt = $urandom;
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            st = (fl == 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_req(ls, pc, len, dt, fl, st);
        end

        repeat (5) @(posedge clk);
        #2;
        chk("rsp_queue_drained", 32'(exp_rsp.size()), 0);
        chk("mc_queue_drained", 32'(exp_mc.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
